// File: rtl/pixel_seq_ctrl.sv
// Purpose : sequencing controller for the circular pixel buffer; loads a frame of
//           SPI bytes, then rotates the buffer to present pixel pairs to the network.
// Latency : byte write is combinational with its strobe (0 cycles); 3 cycles per pair.
// Backpr. : pair_ready low in PRESENT freezes all state and the buffer; bytes that
//           arrive outside IDLE/LOAD are dropped and flagged on drop_err.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   spi_byte_valid      one-cycle strobe, a new byte is on the buffer's spi_in
//   calc_start          start a calculation (only honoured in FULL)
//   pair_ready          network consumes the presented pair
//   shift_SPI           buffer shift, SPI side
//   write_en            buffer input select: 1 = spi_in, 0 = recirculate top byte
//   network_calc        buffer shift-source select: 1 = network side
//   shift_network       buffer shift, network side
//   pair_valid          buffer outputs hold a valid pixel pair
//   pair_index          index of presented pair, 0..NUM_BYTES/2-1
//   pass_index          index of the current full-image pass
//   frame_loaded        pulse in the cycle the last byte of a frame is written
//   calc_done           pulse at the end of the final pass
//   drop_err            pulse when an SPI byte arrives while not accepting
module pixel_seq_ctrl #(
  parameter  int NUM_BYTES  = 72,
  parameter  int NUM_PASSES = 1,
  localparam int PAIRS      = NUM_BYTES / 2,
  localparam int PW         = $clog2(PAIRS),
  localparam int BW         = $clog2(NUM_BYTES),
  localparam int SW         = $clog2(NUM_PASSES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_byte_valid,
  input  logic          calc_start,
  input  logic          pair_ready,
  output logic          shift_SPI,
  output logic          write_en,
  output logic          network_calc,
  output logic          shift_network,
  output logic          pair_valid,
  output logic [PW-1:0] pair_index,
  output logic [SW-1:0] pass_index,
  output logic          frame_loaded,
  output logic          calc_done,
  output logic          drop_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FULL,
    PRESENT,
    SHIFT_A,
    SHIFT_B,
    DONE
  } state_t;

  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
  localparam logic [PW-1:0] LAST_PAIR = PW'(PAIRS - 1);
  localparam logic [SW-1:0] LAST_PASS = SW'(NUM_PASSES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_byte_cnt;
  logic [BW-1:0] w_byte_cnt_nxt;
  logic [PW-1:0] r_pair_idx;
  logic [PW-1:0] w_pair_idx_nxt;
  logic [SW-1:0] r_pass_idx;
  logic [SW-1:0] w_pass_idx_nxt;

  logic w_shift_spi;
  logic w_write_en;
  logic w_network_calc;
  logic w_shift_network;
  logic w_pair_valid;
  logic w_frame_loaded;
  logic w_calc_done;
  logic w_drop_err;

  // State register and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_pair_idx <= '0;
      r_pass_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_pair_idx <= w_pair_idx_nxt;
      r_pass_idx <= w_pass_idx_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_pair_idx_nxt  = r_pair_idx;
    w_pass_idx_nxt  = r_pass_idx;
    w_shift_spi     = 1'b0;
    w_write_en      = 1'b0;
    w_network_calc  = 1'b0;
    w_shift_network = 1'b0;
    w_pair_valid    = 1'b0;
    w_frame_loaded  = 1'b0;
    w_calc_done     = 1'b0;
    w_drop_err      = 1'b0;

    case (r_state)
      IDLE, LOAD: begin
        // The byte is written in the same cycle as its strobe.
        if (spi_byte_valid) begin
          w_shift_spi = 1'b1;
          w_write_en  = 1'b1;
          if (r_byte_cnt == LAST_BYTE) begin
            w_frame_loaded = 1'b1;
            w_byte_cnt_nxt = '0;
            w_state_nxt    = FULL;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + BW'(1);
            w_state_nxt    = LOAD;
          end
        end
      end

      FULL: begin
        w_drop_err = spi_byte_valid;
        if (calc_start) begin
          w_pair_idx_nxt = '0;
          w_pass_idx_nxt = '0;
          w_state_nxt    = PRESENT;
        end
      end

      PRESENT: begin
        w_network_calc = 1'b1;
        w_pair_valid   = 1'b1;
        w_drop_err     = spi_byte_valid;
        if (pair_ready) begin
          w_state_nxt = SHIFT_A;
        end
      end

      SHIFT_A: begin
        // write_en stays 0 so the top byte recirculates to the bottom.
        w_network_calc  = 1'b1;
        w_shift_network = 1'b1;
        w_drop_err      = spi_byte_valid;
        w_state_nxt     = SHIFT_B;
      end

      SHIFT_B: begin
        w_network_calc  = 1'b1;
        w_shift_network = 1'b1;
        w_drop_err      = spi_byte_valid;
        if (r_pair_idx < LAST_PAIR) begin
          w_pair_idx_nxt = r_pair_idx + PW'(1);
          w_state_nxt    = PRESENT;
        end else begin
          // A full rotation leaves the buffer in its original order, so
          // another pass can start straight away.
          w_pair_idx_nxt = '0;
          if (r_pass_idx < LAST_PASS) begin
            w_pass_idx_nxt = r_pass_idx + SW'(1);
            w_state_nxt    = PRESENT;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end

      DONE: begin
        w_calc_done = 1'b1;
        w_drop_err  = spi_byte_valid;
        w_state_nxt = FULL;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The load-path outputs follow spi_byte_valid combinationally; gating with
  // rst keeps every control line low while reset is held.
  assign shift_SPI     = w_shift_spi & ~rst;
  assign write_en      = w_write_en & ~rst;
  assign frame_loaded  = w_frame_loaded & ~rst;
  assign drop_err      = w_drop_err & ~rst;
  assign network_calc  = w_network_calc;
  assign shift_network = w_shift_network;
  assign pair_valid    = w_pair_valid;
  assign calc_done     = w_calc_done;
  assign pair_index    = r_pair_idx;
  assign pass_index    = r_pass_idx;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Purpose : scoreboard bench for pixel_seq_ctrl with a behavioural model of the
//           circular pixel buffer driven by the controller's buffer control lines.
// Latency : pairs are checked as they are consumed (pair_valid & pair_ready).
// Backpr. : pair_ready is dropped for five PRESENT cycles during one run.
module tb_pixel_seq_ctrl;

  localparam int NB    = 72;
  localparam int NP    = 3;
  localparam int PAIRS = NB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_byte_valid;
  logic       calc_start;
  logic       pair_ready;
  logic [7:0] spi_dat;

  logic       shift_SPI;
  logic       write_en;
  logic       network_calc;
  logic       shift_network;
  logic       pair_valid;
  logic [5:0] pair_index;
  logic [2:0] pass_index;
  logic       frame_loaded;
  logic       calc_done;
  logic       drop_err;

  logic [7:0]  bufm  [NB];
  logic [7:0]  frame [NB];
  logic [7:0]  nxt_in;
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  pixel_seq_ctrl #(.NUM_BYTES(NB), .NUM_PASSES(NP)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_byte_valid(spi_byte_valid),
    .calc_start    (calc_start),
    .pair_ready    (pair_ready),
    .shift_SPI     (shift_SPI),
    .write_en      (write_en),
    .network_calc  (network_calc),
    .shift_network (shift_network),
    .pair_valid    (pair_valid),
    .pair_index    (pair_index),
    .pass_index    (pass_index),
    .frame_loaded  (frame_loaded),
    .calc_done     (calc_done),
    .drop_err      (drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Buffer model and pair scoreboard. Top slot is bufm[0]; pixel_data_2 is
  // bufm[0] and pixel_data_1 is bufm[1]. Sampled mid-cycle, the shift is
  // applied here as the effect of the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("excl_shift", 32'(shift_SPI & shift_network), 32'd0);
      chk("we_vs_nc", 32'(write_en & network_calc), 32'd0);
      if (pair_valid && pair_ready) begin
        if (sb.size() == 0) chk("unexpected_pair", 32'd1, 32'd0);
        else chk("pair", {8'(pass_index), 8'(pair_index), bufm[0], bufm[1]}, sb.pop_front());
      end
      if (shift_SPI || shift_network) begin
        nxt_in = write_en ? spi_dat : bufm[0];
        for (int k = 0; k < NB - 1; k++) bufm[k] = bufm[k+1];
        bufm[NB-1] = nxt_in;
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit last, input bit start);
    spi_byte_valid = 1'b1;
    spi_dat        = b;
    calc_start     = start;
    @(negedge clk);
    chk("ld_ctrl", {shift_SPI, write_en, network_calc}, 3'b110);
    chk("ld_frame_loaded", 32'(frame_loaded), 32'(last));
    @(posedge clk); #1;
    spi_byte_valid = 1'b0;
    calc_start     = 1'b0;
  endtask

  task automatic run_calc(input bit do_bp);
    int first_pv   = -1;
    int bp_st      = 0;
    int held       = 0;
    bit done_seen  = 1'b0;
    bit nxt_ready  = 1'b1;
    bit nxt_spi    = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < PAIRS; k++)
        sb.push_back({8'(p), 8'(k), frame[2*k], frame[2*k+1]});
    @(posedge clk); #1;
    calc_start = 1'b1;
    pair_ready = 1'b1;
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      @(negedge clk);
      if (pair_valid && first_pv < 0) first_pv = c;
      if (calc_done) begin
        done_seen = 1'b1;
        chk("done_latency", 32'(c - first_pv), 32'(3*PAIRS*NP + (do_bp ? 5 : 0)));
      end
      if (do_bp) begin
        if (bp_st == 0 && shift_network && pair_index == 6'd6 && pass_index == 3'd0) begin
          bp_st = 1;
        end else if (bp_st == 1) begin
          bp_st = 2;
        end else if (bp_st == 2) begin
          held++;
          chk("bp_valid", {pair_valid, shift_network}, 2'b10);
          chk("bp_pair", {8'(pair_index), bufm[0], bufm[1]}, {8'd7, frame[14], frame[15]});
          if (held == 3) chk("drop_in_present", {drop_err, shift_SPI, write_en}, 3'b100);
          if (held == 4) chk("drop_one_cycle", 32'(drop_err), 32'd0);
          if (held == 5) bp_st = 3;
        end
      end
      nxt_ready = !(bp_st == 1 || bp_st == 2);
      nxt_spi   = (bp_st == 2 && held == 2);
      @(posedge clk); #1;
      calc_start     = 1'b0;
      pair_ready     = nxt_ready;
      spi_byte_valid = nxt_spi;
      spi_dat        = 8'hEE;
    end
    spi_byte_valid = 1'b0;
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_pulse_end", {calc_done, pair_valid, network_calc}, 3'b000);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst            = 1'b1;
    spi_byte_valid = 1'b0;
    calc_start     = 1'b0;
    pair_ready     = 1'b0;
    spi_dat        = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {shift_SPI, write_en, network_calc, shift_network,
                        pair_valid, frame_loaded, calc_done, drop_err}, 8'h00);
    chk("rst_indices", {pair_index, pass_index}, 9'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // calc_start in IDLE is ignored.
    calc_start = 1'b1;
    @(negedge clk);
    chk("idle_start_nc", 32'(network_calc), 32'd0);
    @(posedge clk); #1;
    calc_start = 1'b0;
    @(negedge clk);
    chk("idle_start_pv", {pair_valid, network_calc}, 2'b00);
    @(posedge clk); #1;

    // Partial frame, then asynchronous reset mid-load with a strobe present.
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i), 1'b0, 1'b0);
    spi_byte_valid = 1'b1;
    spi_dat        = 8'h55;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", {shift_SPI, write_en, network_calc, shift_network,
                              pair_valid, frame_loaded, calc_done, drop_err}, 8'h00);
    spi_byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Full frame; calc_start at byte 40 and with the final write is ignored.
    for (int i = 0; i < NB; i++) begin
      frame[i] = 8'(i);
      send_byte(8'(i), i == NB - 1, i == 40 || i == NB - 1);
    end
    @(negedge clk);
    chk("full_idle", {pair_valid, network_calc, frame_loaded}, 3'b000);

    // Byte arriving in FULL is dropped.
    @(posedge clk); #1;
    spi_byte_valid = 1'b1;
    spi_dat        = 8'h77;
    @(negedge clk);
    chk("drop_in_full", {drop_err, shift_SPI, write_en}, 3'b100);
    @(posedge clk); #1;
    spi_byte_valid = 1'b0;
    @(negedge clk);
    chk("drop_full_clear", 32'(drop_err), 32'd0);

    run_calc(1'b0);
    run_calc(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
